jump_target_unit: RTL and testbench

Registered jump-target generator for the ID stage of the MIPS pipeline. It is the parametrised successor of the combinational jump-address calculator and resolves J, JAL and JR targets. It adds a return-address stack (RAS) that predicts JR targets and flags mispredictions. The registered redirect feeds the IF-stage PC mux one cycle after the jump is seen in ID.

---
 rtl/jump_pkg.sv | 31 +++
 rtl/jump_ras.sv | 50 +++++
 rtl/jump_target_unit.sv | 102 ++++++++++
 tb/tb_jump_target_unit.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/jump_pkg.sv
// Shared jump-kind encoding and pseudo-direct (J/JAL) target helper for the
// ID-stage jump target unit and its return-address stack.
package jump_pkg;

   typedef enum logic [1:0] {
      JK_NONE = 2'd0,
      JK_J    = 2'd1,
      JK_JAL  = 2'd2,
      JK_JR   = 2'd3
   } jump_kind_t;

   localparam int JP_MAX_W = 64;

   // Concatenates {pc upper bits, idx, shift zeros}; callers truncate to their width.
   function automatic logic [JP_MAX_W-1:0] pseudo_direct(
      input logic [JP_MAX_W-1:0] pc,
      input logic [JP_MAX_W-1:0] idx,
      input int                  idx_w,
      input int                  shift
   );
      logic [JP_MAX_W-1:0] one;
      logic [JP_MAX_W-1:0] field_mask;
      logic [JP_MAX_W-1:0] upper_mask;
      one        = '0;
      one[0]     = 1'b1;
      field_mask = (one << idx_w) - one;
      upper_mask = ~((one << (idx_w + shift)) - one);
      return (pc & upper_mask) | ((idx & field_mask) << shift);
   endfunction

endpackage

// File: rtl/jump_ras.sv
// Circular return-address stack: pushes wrap over the oldest entry, pops on an
// empty stack are ignored. Contents are not reset; only pointer/count/flag are.
module jump_ras #(
   parameter  int DATA_W = 32,
   parameter  int DEPTH  = 4,
   localparam int PTR_W  = $clog2(DEPTH),
   localparam int CNT_W  = PTR_W + 1
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              push,
   input  logic              pop,
   input  logic [DATA_W-1:0] push_data,
   output logic [DATA_W-1:0] top_data,
   output logic [CNT_W-1:0]  count,
   output logic              overflow
);

   logic [DATA_W-1:0] stack [DEPTH];
   logic [PTR_W-1:0]  top_ptr;
   logic [PTR_W-1:0]  top_idx;
   logic              full;
   logic              empty;

   // top_ptr names the next free slot, so the live top sits one below it.
   assign top_idx  = top_ptr - 1'b1;
   assign full     = (count == CNT_W'(DEPTH));
   assign empty    = (count == '0);
   assign top_data = stack[top_idx];

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         top_ptr  <= '0;
         count    <= '0;
         overflow <= 1'b0;
      end else if (push) begin
         top_ptr <= top_ptr + 1'b1;
         if (full) overflow <= 1'b1;
         else      count    <= count + 1'b1;
      end else if (pop && !empty) begin
         top_ptr <= top_ptr - 1'b1;
         count   <= count - 1'b1;
      end
   end

   always_ff @(posedge clock) begin
      if (push) stack[top_ptr] <= push_data;
   end

endmodule

// File: rtl/jump_target_unit.sv
// Registered J/JAL/JR redirect generator for ID with optional return-address
// stack prediction of JR targets (built when JUMP_TARGET_RAS_EN is defined).
module jump_target_unit
   import jump_pkg::*;
#(
   parameter  int ADDR_W     = 32,
   parameter  int IDX_W      = 26,
   parameter  int WORD_SHIFT = 2,
   parameter  int RAS_DEPTH  = 4,
   localparam int CNT_W      = $clog2(RAS_DEPTH) + 1
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              id_valid,
   input  logic [1:0]        id_kind,
   input  logic [IDX_W-1:0]  instr_index,
   input  logic [ADDR_W-1:0] pc_plus_4,
   input  logic [ADDR_W-1:0] rs_value,
   input  logic              stall,
   input  logic              flush,
   output logic              redirect_valid,
   output logic [ADDR_W-1:0] redirect_target,
   output logic [ADDR_W-1:0] ras_pred_target,
   output logic              ras_pred_hit,
   output logic [CNT_W-1:0]  ras_count,
   output logic              ras_overflow
);

   jump_kind_t        kind_p0;
   logic              accept_p0;
   logic [ADDR_W-1:0] pd_target_p0;
   logic [ADDR_W-1:0] target_p0;

   assign kind_p0      = jump_kind_t'(id_kind);
   assign accept_p0    = id_valid && !stall && !flush && (kind_p0 != JK_NONE);
   assign pd_target_p0 = ADDR_W'(pseudo_direct(JP_MAX_W'(pc_plus_4), JP_MAX_W'(instr_index),
                                                IDX_W, WORD_SHIFT));
   assign target_p0    = (kind_p0 == JK_JR) ? rs_value : pd_target_p0;

   // ---- ID -> IF redirect register ----
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         redirect_valid  <= 1'b0;
         redirect_target <= '0;
      end else if (flush) begin
         redirect_valid <= 1'b0;
      end else if (!stall) begin
         redirect_valid <= accept_p0;
         if (accept_p0) redirect_target <= target_p0;
      end
   end

`ifdef JUMP_TARGET_RAS_EN
   logic              push_p0;
   logic              pop_p0;
   logic [ADDR_W-1:0] ras_top;
   logic [CNT_W-1:0]  ras_cnt;
   logic              ras_ovf;

   assign push_p0 = accept_p0 && (kind_p0 == JK_JAL);
   assign pop_p0  = accept_p0 && (kind_p0 == JK_JR);

   jump_ras #(
      .DATA_W (ADDR_W),
      .DEPTH  (RAS_DEPTH)
   ) u_ras (
      .clock     (clock),
      .reset     (reset),
      .push      (push_p0),
      .pop       (pop_p0),
      .push_data (pc_plus_4),
      .top_data  (ras_top),
      .count     (ras_cnt),
      .overflow  (ras_ovf)
   );

   // ---- JR prediction register, updated with the redirect it belongs to ----
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         ras_pred_target <= '0;
         ras_pred_hit    <= 1'b0;
      end else if (pop_p0) begin
         if (ras_cnt == '0) begin
            ras_pred_target <= '0;
            ras_pred_hit    <= 1'b0;
         end else begin
            ras_pred_target <= ras_top;
            ras_pred_hit    <= (ras_top == rs_value);
         end
      end
   end

   assign ras_count    = ras_cnt;
   assign ras_overflow = ras_ovf;
`else
   assign ras_pred_target = '0;
   assign ras_pred_hit    = 1'b0;
   assign ras_count       = '0;
   assign ras_overflow    = 1'b0;
`endif

endmodule

// File: tb/tb_jump_target_unit.sv
// Directed bench for jump_target_unit; RAS expectations collapse to zero when
// JUMP_TARGET_RAS_EN is not defined.
module tb_jump_target_unit;

   logic        clock;
   logic        reset;
   logic        id_valid;
   logic [1:0]  id_kind;
   logic [25:0] instr_index;
   logic [31:0] pc_plus_4;
   logic [31:0] rs_value;
   logic        stall;
   logic        flush;

   logic        redirect_valid;
   logic [31:0] redirect_target;
   logic [31:0] ras_pred_target;
   logic        ras_pred_hit;
   logic [2:0]  ras_count;
   logic        ras_overflow;

   logic        w0_redirect_valid;
   logic [31:0] w0_redirect_target;
   logic [31:0] w0_ras_pred_target;
   logic        w0_ras_pred_hit;
   logic [2:0]  w0_ras_count;
   logic        w0_ras_overflow;

   int checks = 0;
   int errors = 0;

`ifdef JUMP_TARGET_RAS_EN
   localparam bit RAS_EN = 1'b1;
`else
   localparam bit RAS_EN = 1'b0;
`endif

   localparam logic [1:0] K_NONE = 2'd0;
   localparam logic [1:0] K_J    = 2'd1;
   localparam logic [1:0] K_JAL  = 2'd2;
   localparam logic [1:0] K_JR   = 2'd3;

   jump_target_unit #(
      .ADDR_W(32), .IDX_W(26), .WORD_SHIFT(2), .RAS_DEPTH(4)
   ) dut (
      .clock           (clock),
      .reset           (reset),
      .id_valid        (id_valid),
      .id_kind         (id_kind),
      .instr_index     (instr_index),
      .pc_plus_4       (pc_plus_4),
      .rs_value        (rs_value),
      .stall           (stall),
      .flush           (flush),
      .redirect_valid  (redirect_valid),
      .redirect_target (redirect_target),
      .ras_pred_target (ras_pred_target),
      .ras_pred_hit    (ras_pred_hit),
      .ras_count       (ras_count),
      .ras_overflow    (ras_overflow)
   );

   jump_target_unit #(
      .ADDR_W(32), .IDX_W(26), .WORD_SHIFT(0), .RAS_DEPTH(4)
   ) dut_w0 (
      .clock           (clock),
      .reset           (reset),
      .id_valid        (id_valid),
      .id_kind         (id_kind),
      .instr_index     (instr_index),
      .pc_plus_4       (pc_plus_4),
      .rs_value        (rs_value),
      .stall           (stall),
      .flush           (flush),
      .redirect_valid  (w0_redirect_valid),
      .redirect_target (w0_redirect_target),
      .ras_pred_target (w0_ras_pred_target),
      .ras_pred_hit    (w0_ras_pred_hit),
      .ras_count       (w0_ras_count),
      .ras_overflow    (w0_ras_overflow)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [63:0] re(input logic [63:0] v);
      return RAS_EN ? v : 64'd0;
   endfunction

   task automatic drive(input logic v, input logic [1:0] k, input logic [25:0] idx,
                        input logic [31:0] pc, input logic [31:0] rs);
      id_valid    = v;
      id_kind     = k;
      instr_index = idx;
      pc_plus_4   = pc;
      rs_value    = rs;
   endtask

   task automatic tick;
      @(posedge clock);
      #1;
   endtask

   initial begin
      reset = 1'b1;
      stall = 1'b0;
      flush = 1'b0;
      drive(1'b0, K_NONE, 26'd0, 32'd0, 32'd0);
      #1;
      chk("rst_valid",  64'(redirect_valid), 64'd0);
      chk("rst_target", 64'(redirect_target), 64'd0);
      chk("rst_count",  64'(ras_count), 64'd0);
      chk("rst_ovf",    64'(ras_overflow), 64'd0);
      chk("rst_pred",   64'(ras_pred_target), 64'd0);
      chk("rst_hit",    64'(ras_pred_hit), 64'd0);
      tick();
      tick();
      #4 reset = 1'b0;

      // J: byte-addressed and word-indexed builds
      drive(1'b1, K_J, 26'h0000040, 32'h9000_0010, 32'd0);
      tick();
      drive(1'b0, K_NONE, 26'd0, 32'd0, 32'd0);
      chk("j_valid",     64'(redirect_valid), 64'd1);
      chk("j_target",    64'(redirect_target), 64'h9000_0100);
      chk("j_w0_target", 64'(w0_redirect_target), 64'h9000_0040);
      chk("j_count",     64'(ras_count), 64'd0);
      tick();
      chk("j_pulse_end", 64'(redirect_valid), 64'd0);
      chk("j_hold",      64'(redirect_target), 64'h9000_0100);

      // JAL then matching JR
      drive(1'b1, K_JAL, 26'h0100000, 32'h0040_0008, 32'd0);
      tick();
      chk("jal_valid",  64'(redirect_valid), 64'd1);
      chk("jal_target", 64'(redirect_target), 64'h0040_0000);
      chk("jal_count",  64'(ras_count), re(64'd1));
      drive(1'b1, K_JR, 26'd0, 32'd0, 32'h0040_0008);
      tick();
      drive(1'b0, K_NONE, 26'd0, 32'd0, 32'd0);
      chk("jr_valid",  64'(redirect_valid), 64'd1);
      chk("jr_target", 64'(redirect_target), 64'h0040_0008);
      chk("jr_pred",   64'(ras_pred_target), re(64'h0040_0008));
      chk("jr_hit",    64'(ras_pred_hit), re(64'd1));
      chk("jr_count",  64'(ras_count), 64'd0);
      tick();

      // Five JALs into a four-deep stack
      for (int k = 1; k <= 5; k++) begin
         drive(1'b1, K_JAL, 26'd0, 32'h1000_0000 + 32'(k) * 32'h100, 32'd0);
         tick();
         if (k == 4) begin
            chk("ovf_4_count", 64'(ras_count), re(64'd4));
            chk("ovf_4_flag",  64'(ras_overflow), 64'd0);
         end
      end
      chk("ovf_5_count",  64'(ras_count), re(64'd4));
      chk("ovf_5_flag",   64'(ras_overflow), re(64'd1));
      chk("ovf_5_target", 64'(redirect_target), 64'h1000_0000);

      drive(1'b1, K_JR, 26'd0, 32'd0, 32'h1000_0500);
      tick();
      chk("pop1_pred",  64'(ras_pred_target), re(64'h1000_0500));
      chk("pop1_hit",   64'(ras_pred_hit), re(64'd1));
      chk("pop1_count", 64'(ras_count), re(64'd3));
      drive(1'b1, K_JR, 26'd0, 32'd0, 32'h0000_DEAD);
      tick();
      chk("pop2_pred",   64'(ras_pred_target), re(64'h1000_0400));
      chk("pop2_hit",    64'(ras_pred_hit), 64'd0);
      chk("pop2_target", 64'(redirect_target), 64'h0000_DEAD);
      drive(1'b1, K_JR, 26'd0, 32'd0, 32'h1000_0300);
      tick();
      chk("pop3_pred", 64'(ras_pred_target), re(64'h1000_0300));
      drive(1'b1, K_JR, 26'd0, 32'd0, 32'h1000_0200);
      tick();
      chk("pop4_pred",  64'(ras_pred_target), re(64'h1000_0200));
      chk("pop4_hit",   64'(ras_pred_hit), re(64'd1));
      chk("pop4_count", 64'(ras_count), 64'd0);
      drive(1'b1, K_JR, 26'd0, 32'd0, 32'd0);
      tick();
      drive(1'b0, K_NONE, 26'd0, 32'd0, 32'd0);
      chk("pop5_pred",   64'(ras_pred_target), 64'd0);
      chk("pop5_hit",    64'(ras_pred_hit), 64'd0);
      chk("pop5_count",  64'(ras_count), 64'd0);
      chk("pop5_sticky", 64'(ras_overflow), re(64'd1));
      tick();

      // JAL killed by flush
      drive(1'b1, K_JAL, 26'h0000077, 32'h0000_1004, 32'd0);
      flush = 1'b1;
      tick();
      flush = 1'b0;
      drive(1'b0, K_NONE, 26'd0, 32'd0, 32'd0);
      chk("flush_valid", 64'(redirect_valid), 64'd0);
      chk("flush_count", 64'(ras_count), 64'd0);

      // Flush beats stall and cancels a pending pulse
      drive(1'b1, K_J, 26'h0000010, 32'h0000_2000, 32'd0);
      tick();
      drive(1'b0, K_NONE, 26'd0, 32'd0, 32'd0);
      chk("pend_valid", 64'(redirect_valid), 64'd1);
      stall = 1'b1;
      flush = 1'b1;
      tick();
      flush = 1'b0;
      stall = 1'b0;
      chk("pend_flushed", 64'(redirect_valid), 64'd0);

      // JAL held by a two-cycle stall
      drive(1'b1, K_JAL, 26'h0000123, 32'h0050_0004, 32'd0);
      stall = 1'b1;
      tick();
      chk("stall1_valid", 64'(redirect_valid), 64'd0);
      tick();
      chk("stall2_valid", 64'(redirect_valid), 64'd0);
      chk("stall2_count", 64'(ras_count), 64'd0);
      stall = 1'b0;
      tick();
      drive(1'b0, K_NONE, 26'd0, 32'd0, 32'd0);
      chk("unstall_valid",  64'(redirect_valid), 64'd1);
      chk("unstall_target", 64'(redirect_target), 64'h0000_048C);
      chk("unstall_count",  64'(ras_count), re(64'd1));
      stall = 1'b1;
      tick();
      chk("stall_extends", 64'(redirect_valid), 64'd1);
      stall = 1'b0;
      tick();
      chk("extend_end", 64'(redirect_valid), 64'd0);

      // Reset in the cycle of a pending pulse
      drive(1'b1, K_JAL, 26'h0000200, 32'h0060_0000, 32'd0);
      tick();
      drive(1'b0, K_NONE, 26'd0, 32'd0, 32'd0);
      chk("prerst_valid", 64'(redirect_valid), 64'd1);
      chk("prerst_count", 64'(ras_count), re(64'd2));
      #2 reset = 1'b1;
      #1;
      chk("async_valid",  64'(redirect_valid), 64'd0);
      chk("async_target", 64'(redirect_target), 64'd0);
      chk("async_count",  64'(ras_count), 64'd0);
      chk("async_ovf",    64'(ras_overflow), 64'd0);
      #2 reset = 1'b0;
      tick();
      chk("postrst_valid", 64'(redirect_valid), 64'd0);
      chk("postrst_count", 64'(ras_count), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
